// File: rtl/led_pkg.sv
// Shared definitions for the running-light generator, its receive-side
// decoder and the bench model.
//   led_state_e : decoder FSM states
//   LED0..LED3  : the four legal one-hot codes on the 4-bit bus
//   led_next()  : the next pattern in the rotation
//                 dir = 0 : 0001 -> 0010 -> 0100 -> 1000 -> 0001
//                 dir = 1 : the reverse order
package led_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        FAULT   = 2'd3
    } led_state_e;

    localparam logic [3:0] LED0 = 4'b0001;
    localparam logic [3:0] LED1 = 4'b0010;
    localparam logic [3:0] LED2 = 4'b0100;
    localparam logic [3:0] LED3 = 4'b1000;

    // Rotation by one position. A non-one-hot input rotates into another
    // non-one-hot value, so it can never match a legal successor.
    function automatic logic [3:0] led_next(input logic [3:0] data, input logic dir);
        return dir ? {data[0], data[3:1]} : {data[2:0], data[3]};
    endfunction

endpackage

// File: rtl/led_onehot_dec.sv
// Combinational one-hot decoder for the 4-bit running-light bus.
//   data  in  4 : pattern bus
//   pos   out 2 : index of the set bit (0 when the code is not one-hot)
//   legal out 1 : data has exactly one bit set
module led_onehot_dec
    import led_pkg::*;
(
    input  logic [3:0] data,
    output logic [1:0] pos,
    output logic       legal
);

    always_comb begin
        pos   = 2'd0;
        legal = 1'b1;
        case (data)
            LED0:    pos = 2'd0;
            LED1:    pos = 2'd1;
            LED2:    pos = 2'd2;
            LED3:    pos = 2'd3;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/led_pattern_decoder.sv
// Receive-side monitor for the 4-bit running-light bus. Samples data under
// the generator enable, decodes the lit position, locks onto the expected
// rotation and reports illegal codes, wrong steps and stalls.
//   clk       in  1 : clock, rising edge
//   res       in  1 : asynchronous active-high reset
//   sw        in  1 : generator enable
//   data      in  4 : pattern bus
//   pos       out 2 : index of the set bit, valid while pos_valid
//   pos_valid out 1 : state is LOCKED
//   locked    out 1 : state is LOCKED
//   err       out 1 : one-cycle pulse per error detected while LOCKED
//   fault     out 1 : sticky error state, cleared only by res
//   step_cnt  out 8 : correct steps seen while LOCKED, wraps 255 -> 0
//   dbg_state out 2 : current FSM state
module led_pattern_decoder
    import led_pkg::*;
#(
    parameter int LOCK_COUNT = 4,
    parameter int ERR_LIMIT  = 2,
    parameter int TIMEOUT    = 16,
    parameter int DIR        = 0
) (
    input  logic       clk,
    input  logic       res,
    input  logic       sw,
    input  logic [3:0] data,
    output logic [1:0] pos,
    output logic       pos_valid,
    output logic       locked,
    output logic       err,
    output logic       fault,
    output logic [7:0] step_cnt,
    output led_state_e dbg_state
);

    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int HW = $clog2(TIMEOUT + 1);
    localparam int EW = $clog2(ERR_LIMIT + 1);

    localparam logic [GW-1:0] LOCK_C = GW'(LOCK_COUNT);
    localparam logic [HW-1:0] TO_C   = HW'(TIMEOUT);
    localparam logic [EW-1:0] ERR_C  = EW'(ERR_LIMIT);
    localparam logic          DIR_B  = (DIR != 0);

    led_state_e    state;
    logic [3:0]    prev;
    logic [GW-1:0] good_cnt;
    logic [HW-1:0] hold_cnt;
    logic [EW-1:0] err_cnt;

    logic [1:0]    dec_pos;
    logic          legal;
    logic          change;
    logic          good_step;
    logic          bad_step;
    logic [GW-1:0] good_inc;
    logic [HW-1:0] hold_inc;
    logic [EW-1:0] err_inc;
    logic          timeout;

    led_onehot_dec u_dec (
        .data  (data),
        .pos   (dec_pos),
        .legal (legal)
    );

    always_comb begin
        change    = (data != prev);
        good_step = change && legal && (data == led_next(prev, DIR_B));
        // An illegal code counts as bad even when the bus is not moving,
        // but only while the generator is enabled.
        bad_step  = (change && !good_step) || (sw && !legal);
        good_inc  = good_cnt + GW'(1);
        err_inc   = err_cnt + EW'(1);
        hold_inc  = (hold_cnt == TO_C) ? hold_cnt : hold_cnt + HW'(1);
        // Stall: the pattern has now stood still for TIMEOUT edges since the
        // last good step. Only possible without a change, so it can never
        // coincide with a change-driven bad step; both merge into one error.
        timeout   = !change && (hold_inc == TO_C);
    end

    assign dbg_state = state;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state     <= IDLE;
            prev      <= 4'd0;
            pos       <= 2'd0;
            pos_valid <= 1'b0;
            locked    <= 1'b0;
            err       <= 1'b0;
            fault     <= 1'b0;
            step_cnt  <= 8'd0;
            good_cnt  <= '0;
            hold_cnt  <= '0;
            err_cnt   <= '0;
        end else begin
            prev <= data;
            err  <= 1'b0;
            // pos tracks the bus regardless of state; pos_valid qualifies it.
            if (legal) begin
                pos <= dec_pos;
            end

            case (state)
                IDLE: begin
                    good_cnt <= '0;
                    hold_cnt <= '0;
                    err_cnt  <= '0;
                    if (sw) begin
                        state <= ACQUIRE;
                    end
                end

                ACQUIRE: begin
                    if (!sw) begin
                        state    <= IDLE;
                        good_cnt <= '0;
                        hold_cnt <= '0;
                        err_cnt  <= '0;
                    end else if (good_step) begin
                        good_cnt <= good_inc;
                        if (good_inc == LOCK_C) begin
                            state     <= LOCKED;
                            locked    <= 1'b1;
                            pos_valid <= 1'b1;
                            hold_cnt  <= '0;
                        end
                    end else if (bad_step) begin
                        good_cnt <= '0;
                    end
                end

                LOCKED: begin
                    // sw low beats any simultaneous error: no err pulse.
                    if (!sw) begin
                        state     <= IDLE;
                        locked    <= 1'b0;
                        pos_valid <= 1'b0;
                        good_cnt  <= '0;
                        hold_cnt  <= '0;
                        err_cnt   <= '0;
                    end else if (bad_step || timeout) begin
                        err       <= 1'b1;
                        err_cnt   <= err_inc;
                        good_cnt  <= '0;
                        hold_cnt  <= '0;
                        locked    <= 1'b0;
                        pos_valid <= 1'b0;
                        if (err_inc == ERR_C) begin
                            state <= FAULT;
                            fault <= 1'b1;
                        end else begin
                            state <= ACQUIRE;
                        end
                    end else if (good_step) begin
                        step_cnt <= step_cnt + 8'd1;
                        hold_cnt <= '0;
                    end else if (!change) begin
                        hold_cnt <= hold_inc;
                    end
                end

                FAULT: begin
                    // Sticky until res; sw and data are ignored.
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_pattern_decoder.sv
// Self-checking bench for led_pattern_decoder with default parameters
// (LOCK_COUNT=4, ERR_LIMIT=2, TIMEOUT=16, DIR=0).
module tb_led_pattern_decoder;
    import led_pkg::*;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       res;
    logic       sw;
    logic [3:0] data;

    logic [1:0] pos;
    logic       pos_valid;
    logic       locked;
    logic       err;
    logic       fault;
    logic [7:0] step_cnt;
    led_state_e dbg_state;

    always #5 clk = ~clk;

    led_pattern_decoder dut (
        .clk       (clk),
        .res       (res),
        .sw        (sw),
        .data      (data),
        .pos       (pos),
        .pos_valid (pos_valid),
        .locked    (locked),
        .err       (err),
        .fault     (fault),
        .step_cnt  (step_cnt),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    // word = {state, pos_valid, locked, err, fault, pos, step_cnt}
    logic [15:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [15:0] pack_exp(input led_state_e st, input logic [1:0] p,
                                             input logic e, input logic f, input logic [7:0] sc);
        logic lk;
        lk = (st == LOCKED);
        return {st, lk, lk, e, f, p, sc};
    endfunction

    function automatic logic [15:0] actual_word();
        return {dbg_state, pos_valid, locked, err, fault, pos, step_cnt};
    endfunction

    task automatic check_word(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got st=%0d pv=%b lk=%b err=%b flt=%b pos=%0d step=%0d, expected st=%0d pv=%b lk=%b err=%b flt=%b pos=%0d step=%0d",
                     name, act[15:14], act[13], act[12], act[11], act[10], act[9:8], act[7:0],
                     exp[15:14], exp[13], exp[12], exp[11], exp[10], exp[9:8], exp[7:0]);
        end
    endtask

    // ---------------- driver ----------------
    // Called at posedge+1: drive inputs, record expectation, check after the
    // next edge.
    task automatic apply(input string name, input logic s, input logic [3:0] d,
                         input led_state_e st, input logic [1:0] p, input logic e,
                         input logic f, input logic [7:0] sc);
        sw   = s;
        data = d;
        exp_q.push_back(pack_exp(st, p, e, f, sc));
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            check_word(name, actual_word(), exp_q.pop_front());
        end
    endtask

    // Reset held for dur_ns, checked while asserted, released at posedge+1.
    task automatic do_reset(input int dur_ns);
        res  = 1'b1;
        sw   = 1'b0;
        data = 4'b0000;
        #(dur_ns);
        check_word("reset_values", actual_word(), 16'h0000);
        @(posedge clk);
        #1;
        res = 1'b0;
    endtask

    // Four good steps from a freshly reset bus (prev = 0000).
    task automatic lock_from_reset(input string name);
        apply(name, 1'b1, 4'b0001, ACQUIRE, 2'd0, 1'b0, 1'b0, 8'd0);
        apply(name, 1'b1, 4'b0010, ACQUIRE, 2'd1, 1'b0, 1'b0, 8'd0);
        apply(name, 1'b1, 4'b0100, ACQUIRE, 2'd2, 1'b0, 1'b0, 8'd0);
        apply(name, 1'b1, 4'b1000, ACQUIRE, 2'd3, 1'b0, 1'b0, 8'd0);
        apply(name, 1'b1, 4'b0001, LOCKED,  2'd0, 1'b0, 1'b0, 8'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       sw;
        logic [3:0] data;
        led_state_e st;
        logic [1:0] pos;
        logic       err;
        logic       fault;
        logic [7:0] sc;
    } vec_t;

    vec_t tbl[13];

    initial begin
        // idle: illegal codes with sw=0 change nothing
        tbl[0]  = '{1'b0, 4'b0000, IDLE,    2'd0, 1'b0, 1'b0, 8'd0};
        tbl[1]  = '{1'b0, 4'b0011, IDLE,    2'd0, 1'b0, 1'b0, 8'd0};
        tbl[2]  = '{1'b0, 4'b0110, IDLE,    2'd0, 1'b0, 1'b0, 8'd0};
        tbl[3]  = '{1'b0, 4'b0000, IDLE,    2'd0, 1'b0, 1'b0, 8'd0};
        // enable, then four good steps to lock
        tbl[4]  = '{1'b1, 4'b0001, ACQUIRE, 2'd0, 1'b0, 1'b0, 8'd0};
        tbl[5]  = '{1'b1, 4'b0010, ACQUIRE, 2'd1, 1'b0, 1'b0, 8'd0};
        tbl[6]  = '{1'b1, 4'b0100, ACQUIRE, 2'd2, 1'b0, 1'b0, 8'd0};
        tbl[7]  = '{1'b1, 4'b1000, ACQUIRE, 2'd3, 1'b0, 1'b0, 8'd0};
        tbl[8]  = '{1'b1, 4'b0001, LOCKED,  2'd0, 1'b0, 1'b0, 8'd0};
        // counted steps while locked
        tbl[9]  = '{1'b1, 4'b0010, LOCKED,  2'd1, 1'b0, 1'b0, 8'd1};
        tbl[10] = '{1'b1, 4'b0100, LOCKED,  2'd2, 1'b0, 1'b0, 8'd2};
        tbl[11] = '{1'b1, 4'b1000, LOCKED,  2'd3, 1'b0, 1'b0, 8'd3};
        tbl[12] = '{1'b1, 4'b0001, LOCKED,  2'd0, 1'b0, 1'b0, 8'd4};
    end

    // ---------------- test ----------------
    initial begin
        res  = 1'b1;
        sw   = 1'b0;
        data = 4'b0000;
        #1;
        do_reset(1000);

        foreach (tbl[i]) begin
            apply("table", tbl[i].sw, tbl[i].data, tbl[i].st, tbl[i].pos,
                  tbl[i].err, tbl[i].fault, tbl[i].sc);
        end

        // step_cnt wraps after 256 steps from lock
        for (int k = 5; k <= 256; k++) begin
            apply("wrap", 1'b1, 4'(1 << (k % 4)), LOCKED, 2'(k % 4), 1'b0, 1'b0, 8'(k));
        end

        // wrong step 0010 -> 1000: one err pulse, back to ACQUIRE
        apply("pre_wrong", 1'b1, 4'b0010, LOCKED,  2'd1, 1'b0, 1'b0, 8'd1);
        apply("wrong1",    1'b1, 4'b1000, ACQUIRE, 2'd3, 1'b1, 1'b0, 8'd1);
        // relock; first cycle also shows err was a single pulse
        apply("relock",    1'b1, 4'b0001, ACQUIRE, 2'd0, 1'b0, 1'b0, 8'd1);
        apply("relock",    1'b1, 4'b0010, ACQUIRE, 2'd1, 1'b0, 1'b0, 8'd1);
        apply("relock",    1'b1, 4'b0100, ACQUIRE, 2'd2, 1'b0, 1'b0, 8'd1);
        apply("relock",    1'b1, 4'b1000, LOCKED,  2'd3, 1'b0, 1'b0, 8'd1);
        // second wrong step reaches ERR_LIMIT
        apply("wrong2",    1'b1, 4'b0100, FAULT,   2'd2, 1'b1, 1'b1, 8'd1);
        // FAULT is sticky with sw toggling; pos still follows legal codes
        apply("fault_hold", 1'b0, 4'b0001, FAULT, 2'd0, 1'b0, 1'b1, 8'd1);
        apply("fault_hold", 1'b1, 4'b0010, FAULT, 2'd1, 1'b0, 1'b1, 8'd1);
        apply("fault_hold", 1'b0, 4'b0000, FAULT, 2'd1, 1'b0, 1'b1, 8'd1);
        apply("fault_hold", 1'b1, 4'b0100, FAULT, 2'd2, 1'b0, 1'b1, 8'd1);

        // asynchronous reset mid-cycle takes effect without a clock edge
        #2;
        res = 1'b1;
        #1;
        check_word("async_reset", actual_word(), 16'h0000);
        @(posedge clk);
        #1;
        res = 1'b0;

        // ---- sw drop clears err_cnt ----
        lock_from_reset("lock2");
        apply("wrong_a",  1'b1, 4'b0100, ACQUIRE, 2'd2, 1'b1, 1'b0, 8'd0);
        apply("relock2",  1'b1, 4'b1000, ACQUIRE, 2'd3, 1'b0, 1'b0, 8'd0);
        apply("relock2",  1'b1, 4'b0001, ACQUIRE, 2'd0, 1'b0, 1'b0, 8'd0);
        apply("relock2",  1'b1, 4'b0010, ACQUIRE, 2'd1, 1'b0, 1'b0, 8'd0);
        apply("relock2",  1'b1, 4'b0100, LOCKED,  2'd2, 1'b0, 1'b0, 8'd0);
        // wrong step together with sw falling: IDLE, no err
        apply("sw_drop",  1'b0, 4'b0001, IDLE,    2'd0, 1'b0, 1'b0, 8'd0);
        apply("relock3",  1'b1, 4'b0010, ACQUIRE, 2'd1, 1'b0, 1'b0, 8'd0);
        apply("relock3",  1'b1, 4'b0100, ACQUIRE, 2'd2, 1'b0, 1'b0, 8'd0);
        apply("relock3",  1'b1, 4'b1000, ACQUIRE, 2'd3, 1'b0, 1'b0, 8'd0);
        apply("relock3",  1'b1, 4'b0001, ACQUIRE, 2'd0, 1'b0, 1'b0, 8'd0);
        apply("relock3",  1'b1, 4'b0010, LOCKED,  2'd1, 1'b0, 1'b0, 8'd0);
        apply("step",     1'b1, 4'b0100, LOCKED,  2'd2, 1'b0, 1'b0, 8'd1);
        // stall on 0100: error on the 16th unchanged cycle, not FAULT
        for (int i = 1; i <= 16; i++) begin
            apply("stall", 1'b1, 4'b0100, (i == 16) ? ACQUIRE : LOCKED, 2'd2,
                  (i == 16), 1'b0, 8'd1);
        end
        apply("relock4",  1'b1, 4'b1000, ACQUIRE, 2'd3, 1'b0, 1'b0, 8'd1);
        apply("relock4",  1'b1, 4'b0001, ACQUIRE, 2'd0, 1'b0, 1'b0, 8'd1);
        apply("relock4",  1'b1, 4'b0010, ACQUIRE, 2'd1, 1'b0, 1'b0, 8'd1);
        apply("relock4",  1'b1, 4'b0100, LOCKED,  2'd2, 1'b0, 1'b0, 8'd1);
        // illegal 0110: second error since the sw drop -> FAULT, pos holds
        apply("illegal_0110", 1'b1, 4'b0110, FAULT, 2'd2, 1'b1, 1'b1, 8'd1);

        // ---- illegal 0000 while locked ----
        do_reset(30);
        lock_from_reset("lock3");
        apply("step3",        1'b1, 4'b0010, LOCKED,  2'd1, 1'b0, 1'b0, 8'd1);
        apply("illegal_0000", 1'b1, 4'b0000, ACQUIRE, 2'd1, 1'b1, 1'b0, 8'd1);
        apply("acq_illegal",  1'b1, 4'b0000, ACQUIRE, 2'd1, 1'b0, 1'b0, 8'd1);
        apply("idle_again",   1'b0, 4'b0000, IDLE,    2'd1, 1'b0, 1'b0, 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
